// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program-counter sequencer sharing one external address adder
module pc_sequencer #(
    parameter int               WIDTH        = 16,
    parameter logic [WIDTH-1:0] RESET_VECTOR = 16'h0000,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = 16'h0004,
    parameter logic [WIDTH-1:0] INC          = 16'h0001
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             exc_req,
    input  logic             jmp_req,
    input  logic [WIDTH-1:0] jmp_target,
    input  logic             br_req,
    input  logic [WIDTH-1:0] br_base,
    input  logic [WIDTH-1:0] br_offset,
    output logic [WIDTH-1:0] add_op_a,
    output logic [WIDTH-1:0] add_op_b,
    input  logic [WIDTH-1:0] add_sum,
    output logic [WIDTH-1:0] pc,
    output logic             fetch_valid,
    output logic             br_ack,
    output logic             busy
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        CALC = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] target_next;
    logic             fetch_valid_next;
    logic             br_ack_next;
    logic             busy_next;

    // State and output registers; reset forces the boot vector and clears the pending target
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= BOOT;
            pc          <= RESET_VECTOR;
            target      <= '0;
            fetch_valid <= 1'b0;
            br_ack      <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            target      <= target_next;
            fetch_valid <= fetch_valid_next;
            br_ack      <= br_ack_next;
            busy        <= busy_next;
        end
    end

    // Next-state, redirect priority and adder operand steering (adder idles on pc+INC)
    always_comb begin
        state_next       = state;
        pc_next          = pc;
        target_next      = target;
        fetch_valid_next = fetch_valid;
        br_ack_next      = 1'b0;
        busy_next        = busy;
        add_op_a         = pc;
        add_op_b         = INC;

        case (state)
            BOOT: begin
                state_next       = RUN;
                fetch_valid_next = 1'b1;
            end
            RUN: begin
                if (exc_req) begin
                    pc_next = EXC_VECTOR;
                end else if (jmp_req) begin
                    pc_next = jmp_target;
                end else if (br_req) begin
                    add_op_a         = br_base;
                    add_op_b         = br_offset;
                    target_next      = add_sum;
                    state_next       = CALC;
                    fetch_valid_next = 1'b0;
                    busy_next        = 1'b1;
                    br_ack_next      = 1'b1;
                end else if (!stall) begin
                    pc_next = add_sum;
                end
            end
            CALC: begin
                // Redirect always completes here; only an exception can override the target
                state_next       = RUN;
                fetch_valid_next = 1'b1;
                busy_next        = 1'b0;
                pc_next          = exc_req ? EXC_VECTOR : target;
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer with a behavioural model
module tb_pc_sequencer;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         stall = 1'b0;
    logic         exc_req = 1'b0;
    logic         jmp_req = 1'b0;
    logic         br_req = 1'b0;
    logic [W-1:0] jmp_target = '0;
    logic [W-1:0] br_base = '0;
    logic [W-1:0] br_offset = '0;
    logic [W-1:0] add_op_a;
    logic [W-1:0] add_op_b;
    logic [W-1:0] add_sum;
    logic [W-1:0] pc;
    logic         fetch_valid;
    logic         br_ack;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: boot flag, pending branch target, visible outputs
    logic [W-1:0] m_pc;
    logic [W-1:0] m_target;
    bit           m_boot;
    bit           m_pending;
    bit           m_fv;
    bit           m_busy;
    bit           m_ack;

    assign add_sum = add_op_a + add_op_b;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .exc_req     (exc_req),
        .jmp_req     (jmp_req),
        .jmp_target  (jmp_target),
        .br_req      (br_req),
        .br_base     (br_base),
        .br_offset   (br_offset),
        .add_op_a    (add_op_a),
        .add_op_b    (add_op_b),
        .add_sum     (add_sum),
        .pc          (pc),
        .fetch_valid (fetch_valid),
        .br_ack      (br_ack),
        .busy        (busy)
    );

    task automatic model_reset();
        m_pc      = 16'h0000;
        m_target  = 16'h0000;
        m_boot    = 1'b1;
        m_pending = 1'b0;
        m_fv      = 1'b0;
        m_busy    = 1'b0;
        m_ack     = 1'b0;
    endtask

    task automatic model_edge();
        m_ack = 1'b0;
        if (m_boot) begin
            m_boot = 1'b0;
            m_fv   = 1'b1;
        end else if (m_pending) begin
            m_pending = 1'b0;
            m_pc      = exc_req ? 16'h0004 : m_target;
            m_fv      = 1'b1;
            m_busy    = 1'b0;
        end else if (exc_req) begin
            m_pc = 16'h0004;
        end else if (jmp_req) begin
            m_pc = jmp_target;
        end else if (br_req) begin
            m_target  = br_base + br_offset;
            m_pending = 1'b1;
            m_fv      = 1'b0;
            m_busy    = 1'b1;
            m_ack     = 1'b1;
        end else if (!stall) begin
            m_pc = m_pc + 16'h0001;
        end
    endtask

    task automatic clear_inputs();
        stall   = 1'b0;
        exc_req = 1'b0;
        jmp_req = 1'b0;
        br_req  = 1'b0;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic jump_to(input logic [W-1:0] t);
        clear_inputs();
        jmp_req    = 1'b1;
        jmp_target = t;
        tick();
        clear_inputs();
    endtask

    task automatic test_reset();
        logic [W-1:0] exp_seq [4];
        exp_seq = '{16'h0000, 16'h0001, 16'h0002, 16'h0003};
        #1 rst = 1'b1;
        model_reset();
        #1;
        n_tests++;
        if (pc !== 16'h0000 || fetch_valid !== 1'b0 || busy !== 1'b0 || br_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: pc=%h fv=%b busy=%b ack=%b, want pc=0000 fv=0 busy=0 ack=0",
                     pc, fetch_valid, busy, br_ack);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_tests++;
        if (pc !== 16'h0000 || fetch_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL boot_cycle: pc=%h fv=%b, want pc=0000 fv=0", pc, fetch_valid);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++;
            if (pc !== exp_seq[i] || fetch_valid !== 1'b1 || br_ack !== 1'b0 || pc !== m_pc) begin
                n_fail++;
                $display("FAIL free_run[%0d]: pc=%h fv=%b ack=%b, want pc=%h fv=1 ack=0",
                         i, pc, fetch_valid, br_ack, exp_seq[i]);
            end
        end
    endtask

    task automatic test_branch();
        jump_to(16'h0010);
        br_req    = 1'b1;
        br_base   = 16'h0010;
        br_offset = 16'h0020;
        #1;
        n_tests++;
        if (add_op_a !== 16'h0010 || add_op_b !== 16'h0020) begin
            n_fail++;
            $display("FAIL br_operands: a=%h b=%h, want a=0010 b=0020", add_op_a, add_op_b);
        end
        tick();
        clear_inputs();
        n_tests++;
        if (pc !== 16'h0010 || fetch_valid !== 1'b0 || busy !== 1'b1 || br_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL br_accept: pc=%h fv=%b busy=%b ack=%b, want pc=0010 fv=0 busy=1 ack=1",
                     pc, fetch_valid, busy, br_ack);
        end
        tick();
        n_tests++;
        if (pc !== 16'h0030 || fetch_valid !== 1'b1 || busy !== 1'b0 || br_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL br_target: pc=%h fv=%b busy=%b ack=%b, want pc=0030 fv=1 busy=0 ack=0",
                     pc, fetch_valid, busy, br_ack);
        end
        tick();
        n_tests++;
        if (pc !== 16'h0031) begin
            n_fail++;
            $display("FAIL br_after: pc=%h, want 0031", pc);
        end
    endtask

    task automatic test_wrap();
        jump_to(16'hFFFF);
        tick();
        n_tests++;
        if (pc !== 16'h0000) begin
            n_fail++;
            $display("FAIL wrap_inc: pc=%h, want 0000", pc);
        end
        br_req    = 1'b1;
        br_base   = 16'h0002;
        br_offset = 16'hFFFC;
        tick();
        clear_inputs();
        tick();
        n_tests++;
        if (pc !== 16'hFFFE || fetch_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL neg_offset: pc=%h fv=%b, want pc=FFFE fv=1", pc, fetch_valid);
        end
    endtask

    task automatic test_priority();
        jump_to(16'h0100);
        exc_req    = 1'b1;
        jmp_req    = 1'b1;
        jmp_target = 16'h2222;
        br_req     = 1'b1;
        br_base    = 16'h0000;
        br_offset  = 16'h0300;
        tick();
        clear_inputs();
        n_tests++;
        if (pc !== 16'h0004 || br_ack !== 1'b0 || busy !== 1'b0 || fetch_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL exc_priority: pc=%h ack=%b busy=%b fv=%b, want pc=0004 ack=0 busy=0 fv=1",
                     pc, br_ack, busy, fetch_valid);
        end
        tick();
        n_tests++;
        if (pc !== 16'h0005) begin
            n_fail++;
            $display("FAIL exc_no_calc: pc=%h, want 0005", pc);
        end
        jmp_req    = 1'b1;
        jmp_target = 16'h5000;
        br_req     = 1'b1;
        br_base    = 16'h0100;
        br_offset  = 16'h0100;
        tick();
        clear_inputs();
        n_tests++;
        if (pc !== 16'h5000 || br_ack !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL jmp_over_br: pc=%h ack=%b busy=%b, want pc=5000 ack=0 busy=0", pc, br_ack, busy);
        end
        jump_to(16'h1234);
        n_tests++;
        if (pc !== 16'h1234) begin
            n_fail++;
            $display("FAIL jmp_alone: pc=%h, want 1234", pc);
        end
    endtask

    task automatic test_stall();
        jump_to(16'h0040);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (pc !== 16'h0040 || fetch_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: pc=%h fv=%b, want pc=0040 fv=1", i, pc, fetch_valid);
            end
        end
        clear_inputs();
        br_req    = 1'b1;
        br_base   = 16'h0200;
        br_offset = 16'h0011;
        tick();
        clear_inputs();
        stall = 1'b1;
        tick();
        clear_inputs();
        n_tests++;
        if (pc !== 16'h0211 || fetch_valid !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_in_calc: pc=%h fv=%b busy=%b, want pc=0211 fv=1 busy=0", pc, fetch_valid, busy);
        end
        br_req    = 1'b1;
        br_base   = 16'h0300;
        br_offset = 16'h0022;
        tick();
        clear_inputs();
        jmp_req    = 1'b1;
        jmp_target = 16'h7777;
        tick();
        clear_inputs();
        n_tests++;
        if (pc !== 16'h0322) begin
            n_fail++;
            $display("FAIL jmp_in_calc: pc=%h, want 0322", pc);
        end
        br_req    = 1'b1;
        br_base   = 16'h0400;
        br_offset = 16'h0033;
        tick();
        clear_inputs();
        exc_req = 1'b1;
        tick();
        clear_inputs();
        n_tests++;
        if (pc !== 16'h0004 || fetch_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL exc_in_calc: pc=%h fv=%b, want pc=0004 fv=1", pc, fetch_valid);
        end
    endtask

    task automatic test_reset_mid_calc();
        logic [W-1:0] exp_seq [3];
        bit           seen_target;
        exp_seq = '{16'h0000, 16'h0001, 16'h0002};
        jump_to(16'h0400);
        br_req    = 1'b1;
        br_base   = 16'h0400;
        br_offset = 16'h0100;
        tick();
        clear_inputs();
        #2 rst = 1'b1;
        model_reset();
        #1;
        n_tests++;
        if (pc !== 16'h0000 || fetch_valid !== 1'b0 || busy !== 1'b0 || br_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_calc: pc=%h fv=%b busy=%b ack=%b, want pc=0000 fv=0 busy=0 ack=0",
                     pc, fetch_valid, busy, br_ack);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        seen_target = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (pc === 16'h0500) seen_target = 1'b1;
            n_tests++;
            if (pc !== exp_seq[i] || fetch_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL reboot[%0d]: pc=%h fv=%b, want pc=%h fv=1", i, pc, fetch_valid, exp_seq[i]);
            end
        end
        n_tests++;
        if (seen_target) begin
            n_fail++;
            $display("FAIL discarded_target: pc showed 0500, want never");
        end
    endtask

    task automatic test_random();
        logic [W-1:0] exp_a;
        logic [W-1:0] exp_b;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            exc_req    = ($urandom_range(0, 15) == 0);
            jmp_req    = ($urandom_range(0, 7) == 0);
            br_req     = ($urandom_range(0, 5) == 0);
            stall      = ($urandom_range(0, 4) == 0);
            jmp_target = W'($urandom);
            br_base    = W'($urandom);
            br_offset  = W'($urandom);
            #1;
            if (!m_boot && !m_pending && !exc_req && !jmp_req && br_req) begin
                exp_a = br_base;
                exp_b = br_offset;
            end else begin
                exp_a = m_pc;
                exp_b = 16'h0001;
            end
            n_tests++;
            if (add_op_a !== exp_a || add_op_b !== exp_b) begin
                n_fail++;
                $display("FAIL rand_ops[%0d]: a=%h b=%h, want a=%h b=%h", i, add_op_a, add_op_b, exp_a, exp_b);
            end
            tick();
            n_tests++;
            if (pc !== m_pc || fetch_valid !== m_fv || busy !== m_busy || br_ack !== m_ack) begin
                n_fail++;
                $display("FAIL rand_state[%0d]: pc=%h fv=%b busy=%b ack=%b, want pc=%h fv=%b busy=%b ack=%b",
                         i, pc, fetch_valid, busy, br_ack, m_pc, m_fv, m_busy, m_ack);
            end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_branch();
        test_wrap();
        test_priority();
        test_stall();
        test_reset_mid_calc();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter sequencer for the 16-bit RISC core.
- Owns the PC register and time-shares the single external 16-bit address adder between two uses:
  - sequential increment (PC+INC)
  - branch-target computation (base+offset)
- Resolves priority among exception, jump, branch and sequential flow, and presents a registered fetch address with a valid flag to instruction memory.

Parameters:
- WIDTH, 16, address/PC width in bits.
- RESET_VECTOR, 16'h0000, PC value loaded on reset.
- EXC_VECTOR, 16'h0004, PC value loaded on exception.
- INC, 16'h0001, sequential PC increment.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  hold PC in RUN state.
- exc_req  input  1  exception redirect request.
- jmp_req  input  1  absolute jump request.
- jmp_target  input  WIDTH  jump destination.
- br_req  input  1  taken-branch request.
- br_base  input  WIDTH  branch base address.
- br_offset  input  WIDTH  branch offset, two's complement.
- add_op_a  output  WIDTH  adder operand A (combinational).
- add_op_b  output  WIDTH  adder operand B (combinational).
- add_sum  input  WIDTH  adder result; combinational, same-cycle.
- pc  output  WIDTH  registered fetch address.
- fetch_valid  output  1  pc is a valid fetch address this cycle.
- br_ack  output  1  one-cycle pulse: branch accepted.
- busy  output  1  redirect in progress; requests ignored.

Behaviour:
- Reset is asynchronous and active-high; the clock port is clk and the reset port is rst. While rst=1:
  - pc=RESET_VECTOR, state=BOOT
  - fetch_valid=0, br_ack=0, busy=0
  - target register=0
- States: BOOT, RUN, CALC.
- BOOT:
  - Lasts exactly one cycle after rst deasserts, then goes to RUN.
  - fetch_valid goes to 1 on that edge; pc is unchanged.
  - All requests are ignored.
- RUN: priority exc_req > jmp_req > br_req > stall > sequential. At each edge:
  - exc_req: pc<=EXC_VECTOR; fetch_valid stays 1.
  - jmp_req: pc<=jmp_target. The adder is not used.
  - br_req:
    - add_op_a=br_base, add_op_b=br_offset; target register<=add_sum.
    - state<=CALC, fetch_valid<=0, busy<=1, br_ack<=1 for one cycle.
    - pc is unchanged.
  - stall: all registers hold; fetch_valid stays 1.
  - none of the above: add_op_a=pc, add_op_b=INC; pc<=add_sum.
- CALC:
  - Always exactly one cycle: state<=RUN, fetch_valid<=1, busy<=0, br_ack<=0.
  - pc<=target register, unless exc_req=1, in which case pc<=EXC_VECTOR.
  - stall, jmp_req and br_req are ignored; requesters must not rely on them being queued.
- Adder operand defaults:
  - When the sum is unused (BOOT, CALC, stall, exc, jmp), add_op_a=pc and add_op_b=INC.
  - Operands never change without the state or inputs changing (no glitching on unrelated signals).
- br_ack:
  - Registered; high only in the cycle following branch acceptance (the first CALC cycle).
- Arithmetic:
  - Modulo 2^WIDTH, no carry out.
  - 16'hFFFF+1 wraps to 16'h0000.
  - Negative offset (e.g. 16'hFFFC) yields base-4 modulo 2^16.
- Branch cost: 2 cycles from acceptance to the target appearing on pc, with one bubble (fetch_valid=0).
- Reset mid-operation: rst in CALC discards the target; pc=RESET_VECTOR immediately (asynchronous); the sequence restarts at BOOT.
- Simultaneous requests:
  - exc+br in RUN: exception wins, no br_ack, no CALC.
  - jmp+br: jump wins.

Test Plan:
- Reset, release, 4 free-run cycles -> pc 0000 for BOOT, then 0000 (fetch_valid=1), 0001, 0002, 0003; br_ack=0 throughout.
- At pc=0010, br_req with base=0010, offset=0020 -> next cycle pc=0010, fetch_valid=0, busy=1, br_ack=1; following cycle pc=0030, fetch_valid=1, busy=0; then 0031.
- pc=FFFF free-running -> next pc=0000; branch with base=0002, offset=FFFC -> target FFFE.
- exc_req+jmp_req+br_req together at pc=0100 -> pc=0004, no br_ack, busy=0; jmp_req alone with target=1234 -> pc=1234 next cycle.
- stall=1 for 3 cycles at pc=0040 -> pc holds 0040, fetch_valid=1; stall during CALC -> redirect still completes; jmp_req during CALC -> ignored.
- rst pulsed asynchronously mid-CALC (target 0500) -> pc=0000 immediately, fetch_valid=0, busy=0, BOOT restarts; 0500 never appears on pc.
